// File: rtl/dlsc_demosaic_vng6_pkg.sv
// Shared constants and helpers for the VNG6 demosaic front end (sequencer and ROM INDEX tables).
package dlsc_demosaic_vng6_pkg;

    localparam int ROWS           = 5;
    localparam int ST_BITS        = 4;
    localparam int CYCLES_DEFAULT = 12;

    localparam logic [1:0] PH_RG = 2'd0;
    localparam logic [1:0] PH_GR = 2'd1;
    localparam logic [1:0] PH_GB = 2'd2;
    localparam logic [1:0] PH_BG = 2'd3;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    function automatic logic [ST_BITS-1:0] st_next(input logic [ST_BITS-1:0] st_in, input int cycles);
        if (st_in == ST_BITS'(cycles - 1)) begin
            return '0;
        end else begin
            return st_in + ST_BITS'(1);
        end
    endfunction

endpackage

// File: rtl/dlsc_demosaic_vng6_sequencer_if.sv
// Column handshake between the line buffers (master) and the VNG6 sequencer (slave).
interface dlsc_demosaic_vng6_sequencer_if
    import dlsc_demosaic_vng6_pkg::*;
#(
    parameter int DATA = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DATA-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/dlsc_demosaic_vng6_colcnt.sv
// Column position, row-width latch, first/last flags and CFA phase tracking, advanced once per column transfer.
module dlsc_demosaic_vng6_colcnt
    import dlsc_demosaic_vng6_pkg::*;
#(
    parameter int XB = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          xfer,
    input  logic [XB-1:0] cfg_width,
    input  logic [1:0]    cfg_phase,
    output logic          out_first,
    output logic          out_last,
    output logic [1:0]    out_phase
);
    logic [XB-1:0] col_q, col_d;
    logic [XB-1:0] width_q, width_d;
    logic          row_par_q, row_par_d;
    logic          started_q, started_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic [1:0]    phase_q, phase_d;

    logic [XB-1:0] width_eff_s;
    logic          row_cur_s;
    logic          last_s;

    // Width is only taken from cfg at column 0; row parity comes from cfg until the first transfer
    always_comb begin
        width_eff_s = (col_q == '0) ? cfg_width : width_q;
        row_cur_s   = started_q ? row_par_q : cfg_phase[1];
        last_s      = (col_q == width_eff_s);
        col_d       = col_q;
        width_d     = width_q;
        row_par_d   = row_par_q;
        started_d   = started_q;
        first_d     = first_q;
        last_d      = last_q;
        phase_d     = phase_q;
        if (xfer) begin
            first_d   = (col_q == '0);
            last_d    = last_s;
            phase_d   = {row_cur_s, cfg_phase[0] ^ col_q[0]};
            width_d   = width_eff_s;
            col_d     = last_s ? '0 : (col_q + XB'(1));
            row_par_d = last_s ? ~row_cur_s : row_cur_s;
            started_d = 1'b1;
        end else begin
            started_d = started_q;
        end
    end

    // Column tracking registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            width_q   <= '0;
            row_par_q <= 1'b0;
            started_q <= 1'b0;
            first_q   <= 1'b1;
            last_q    <= 1'b0;
            phase_q   <= PH_RG;
        end else begin
            col_q     <= col_d;
            width_q   <= width_d;
            row_par_q <= row_par_d;
            started_q <= started_d;
            first_q   <= first_d;
            last_q    <= last_d;
            phase_q   <= phase_d;
        end
    end

    assign out_first = first_q;
    assign out_last  = last_q;
    assign out_phase = phase_q;

endmodule

// File: rtl/dlsc_demosaic_vng6_sequencer.sv
// VNG6 feeder: serializes one 5-row column per CYCLES enabled clocks and drives the shared st/clk_en.
// Optional stall statistics are built when DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN is defined.
module dlsc_demosaic_vng6_sequencer
    import dlsc_demosaic_vng6_pkg::*;
#(
    parameter int DATA   = 8,
    parameter int CYCLES = CYCLES_DEFAULT,
    parameter int XB     = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [XB-1:0]                 cfg_width,
    input  logic [1:0]                    cfg_phase,
    dlsc_demosaic_vng6_sequencer_if.slave up,
    output logic                          clk_en,
    output logic [ST_BITS-1:0]            st,
    output logic                          push,
    output logic [DATA-1:0]               out_data,
    output logic                          out_first,
    output logic                          out_last,
    output logic [1:0]                    out_phase,
    input  logic                          down_ready
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
    ,
    input  logic                          stat_clear,
    output logic [31:0]                   stat_starve,
    output logic [31:0]                   stat_backpressure
`endif
);
    logic [ST_BITS-1:0]   st_q, st_d;
    logic [ROWS*DATA-1:0] cap_q, cap_d;
    logic                 push_q, push_d;
    logic [DATA-1:0]      out_data_q, out_data_d;
    seq_state_e           state_s;
    logic                 xfer_s;

    // Handshake and stall are held inactive while reset is asserted
    assign state_s     = (st_q == '0) ? SEQ_IDLE : SEQ_RUN;
    assign clk_en      = !rst && down_ready && ((state_s == SEQ_RUN) || up.in_valid);
    assign up.in_ready = !rst && down_ready && (state_s == SEQ_IDLE);
    assign xfer_s      = up.in_ready && up.in_valid;

    // Sequencer state, captured column and registered push/data outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= '0;
            cap_q      <= '0;
            push_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            st_q       <= st_d;
            cap_q      <= cap_d;
            push_q     <= push_d;
            out_data_q <= out_data_d;
        end
    end

    // Next state: advance st and capture the column on each enabled cycle
    always_comb begin
        st_d  = st_q;
        cap_d = cap_q;
        if (clk_en) begin
            st_d = st_next(st_q, CYCLES);
            if (xfer_s) begin
                cap_d = up.in_data;
            end else begin
                cap_d = cap_q;
            end
        end else begin
            st_d = st_q;
        end
    end

    // Row 0 bypasses the capture register so it goes out the cycle after the transfer
    always_comb begin
        push_d     = push_q;
        out_data_d = out_data_q;
        if (!clk_en) begin
            push_d = push_q;
        end else if (xfer_s) begin
            push_d     = 1'b1;
            out_data_d = up.in_data[DATA-1:0];
        end else if ((st_q >= ST_BITS'(1)) && (st_q <= ST_BITS'(ROWS - 1))) begin
            push_d     = 1'b1;
            out_data_d = cap_q[st_q*DATA +: DATA];
        end else begin
            push_d = 1'b0;
        end
    end

    assign st       = st_q;
    assign push     = push_q;
    assign out_data = out_data_q;

    dlsc_demosaic_vng6_colcnt #(
        .XB (XB)
    ) u_colcnt (
        .clk       (clk),
        .rst       (rst),
        .xfer      (xfer_s),
        .cfg_width (cfg_width),
        .cfg_phase (cfg_phase),
        .out_first (out_first),
        .out_last  (out_last),
        .out_phase (out_phase)
    );

`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
    logic [31:0] starve_q, starve_d;
    logic [31:0] bp_q, bp_d;

    // Saturating starvation / backpressure counters
    always_comb begin
        starve_d = starve_q;
        bp_d     = bp_q;
        if (stat_clear) begin
            starve_d = '0;
            bp_d     = '0;
        end else begin
            if ((state_s == SEQ_IDLE) && !up.in_valid && down_ready && !(&starve_q)) begin
                starve_d = starve_q + 32'd1;
            end else begin
                starve_d = starve_q;
            end
            if (!down_ready && !(&bp_q)) begin
                bp_d = bp_q + 32'd1;
            end else begin
                bp_d = bp_q;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            bp_q     <= '0;
        end else begin
            starve_q <= starve_d;
            bp_q     <= bp_d;
        end
    end

    assign stat_starve       = starve_q;
    assign stat_backpressure = bp_q;
`endif

endmodule

// File: tb/tb_dlsc_demosaic_vng6_sequencer.sv
// Directed, table-driven bench for dlsc_demosaic_vng6_sequencer (CYCLES=12, DATA=8).
module tb_dlsc_demosaic_vng6_sequencer;
    localparam int DATA = 8;
    localparam int CYC  = 12;
    localparam int XB   = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [XB-1:0] cfg_width;
    logic [1:0]    cfg_phase;
    logic          clk_en;
    logic [3:0]    st;
    logic          push;
    logic [7:0]    out_data;
    logic          out_first;
    logic          out_last;
    logic [1:0]    out_phase;
    logic          down_ready;
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
    logic          stat_clear;
    logic [31:0]   stat_starve;
    logic [31:0]   stat_backpressure;
    logic [31:0]   snap;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [39:0] data;
        logic        first;
        logic        last;
        logic [1:0]  phase;
    } col_vec_t;

    col_vec_t vec [9];

    dlsc_demosaic_vng6_sequencer_if #(.DATA(DATA)) up_if ();

    dlsc_demosaic_vng6_sequencer #(
        .DATA   (DATA),
        .CYCLES (CYC),
        .XB     (XB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_width  (cfg_width),
        .cfg_phase  (cfg_phase),
        .up         (up_if),
        .clk_en     (clk_en),
        .st         (st),
        .push       (push),
        .out_data   (out_data),
        .out_first  (out_first),
        .out_last   (out_last),
        .out_phase  (out_phase),
        .down_ready (down_ready)
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
        ,
        .stat_clear        (stat_clear),
        .stat_starve       (stat_starve),
        .stat_backpressure (stat_backpressure)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_st"},        32'(st),           32'd0);
        check({tag, "_clk_en"},    32'(clk_en),       32'd0);
        check({tag, "_push"},      32'(push),         32'd0);
        check({tag, "_out_data"},  32'(out_data),     32'd0);
        check({tag, "_out_first"}, 32'(out_first),    32'd1);
        check({tag, "_out_last"},  32'(out_last),     32'd0);
        check({tag, "_in_ready"},  32'(up_if.in_ready), 32'd0);
    endtask

    // One full pixel: transfer at st=0 then CYC-1 enabled cycles, optional stall at st=stall_at
    task automatic send_col(input logic [39:0] d, input logic ef, input logic el,
                            input logic [1:0] eph, input int stall_at, input int stall_len);
        up_if.in_valid = 1'b1;
        up_if.in_data  = d;
        down_ready     = 1'b1;
        #1;
        check("idle_st",       32'(st),             32'd0);
        check("idle_in_ready", 32'(up_if.in_ready), 32'd1);
        check("idle_clk_en",   32'(clk_en),         32'd1);
        tick();
        for (int k = 1; k < CYC; k++) begin
            if (k == stall_at) begin
                down_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    check("stall_clk_en",   32'(clk_en),   32'd0);
                    check("stall_st",       32'(st),       32'(k));
                    check("stall_push",     32'(push),     (k <= 5) ? 32'd1 : 32'd0);
                    check("stall_out_data", 32'(out_data), 32'(d[(k-1)*8 +: 8]));
                    check("stall_first",    32'(out_first), 32'(ef));
                    check("stall_last",     32'(out_last),  32'(el));
                    check("stall_phase",    32'(out_phase), 32'(eph));
                    tick();
                end
                down_ready = 1'b1;
            end
            #1;
            check("run_st",       32'(st),             32'(k));
            check("run_in_ready", 32'(up_if.in_ready), 32'd0);
            check("run_clk_en",   32'(clk_en),         32'd1);
            check("run_push",     32'(push),           (k <= 5) ? 32'd1 : 32'd0);
            if (k <= 5) begin
                check("run_out_data", 32'(out_data), 32'(d[(k-1)*8 +: 8]));
            end
            if (k == 1) begin
                check("col_first", 32'(out_first), 32'(ef));
                check("col_last",  32'(out_last),  32'(el));
                check("col_phase", 32'(out_phase), 32'(eph));
            end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec[0] = '{40'h0504030201, 1'b1, 1'b0, 2'b00};
        vec[1] = '{40'h1514131211, 1'b0, 1'b0, 2'b01};
        vec[2] = '{40'h2524232221, 1'b0, 1'b0, 2'b00};
        vec[3] = '{40'h3534333231, 1'b0, 1'b1, 2'b01};
        vec[4] = '{40'h4544434241, 1'b1, 1'b0, 2'b10};
        vec[5] = '{40'h5554535251, 1'b0, 1'b0, 2'b11};
        vec[6] = '{40'h6564636261, 1'b0, 1'b0, 2'b10};
        vec[7] = '{40'h7574737271, 1'b0, 1'b1, 2'b11};
        vec[8] = '{40'h9594939291, 1'b1, 1'b0, 2'b00};

        rst            = 1'b1;
        cfg_width      = 12'd3;
        cfg_phase      = 2'b00;
        down_ready     = 1'b0;
        up_if.in_valid = 1'b0;
        up_if.in_data  = 40'd0;
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
        stat_clear     = 1'b0;
`endif
        #2;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;

        // Back-to-back stream, width 3
        for (int i = 0; i < 9; i++) begin
            send_col(vec[i].data, vec[i].first, vec[i].last, vec[i].phase, 0, 0);
        end

        // Starvation: no column offered for 7 cycles
        up_if.in_valid = 1'b0;
        down_ready     = 1'b1;
        #1;
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
        snap = stat_starve;
`endif
        for (int i = 0; i < 7; i++) begin
            check("starve_clk_en", 32'(clk_en), 32'd0);
            check("starve_st",     32'(st),     32'd0);
            check("starve_push",   32'(push),   32'd0);
            tick();
        end
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
        check("stat_starve", stat_starve, snap + 32'd7);
        snap = stat_backpressure;
`endif

        // Downstream stall of 3 cycles at st=3 (column 1 of row 2)
        send_col(40'hA5A4A3A2A1, 1'b0, 1'b0, 2'b01, 3, 3);
`ifdef DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN
        check("stat_backpressure", stat_backpressure, snap + 32'd3);
`endif

        // Async reset mid-pixel at st=7 (column 2, not first)
        up_if.in_valid = 1'b1;
        up_if.in_data  = 40'hB5B4B3B2B1;
        down_ready     = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check("pre_rst_st",    32'(st),        32'd7);
        check("pre_rst_first", 32'(out_first), 32'd0);
        check("pre_rst_data",  32'(out_data),  32'hB5);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst            = 1'b0;
        up_if.in_valid = 1'b0;

        // Phase sequence with cfg_phase=01, width 1
        cfg_phase = 2'b01;
        cfg_width = 12'd1;
        send_col(40'hC5C4C3C2C1, 1'b1, 1'b0, 2'b01, 0, 0);
        send_col(40'hC6C5C4C3C2, 1'b0, 1'b1, 2'b00, 0, 0);
        send_col(40'hC7C6C5C4C3, 1'b1, 1'b0, 2'b11, 0, 0);
        send_col(40'hC8C7C6C5C4, 1'b0, 1'b1, 2'b10, 0, 0);
        send_col(40'hC9C8C7C6C5, 1'b1, 1'b0, 2'b01, 0, 0);

        // Width change mid-row is ignored until the next row start
        cfg_width = 12'd0;
        send_col(40'hD5D4D3D2D1, 1'b0, 1'b1, 2'b00, 0, 0);

        // Width 0: every column first and last, row parity toggling
        send_col(40'hE5E4E3E2E1, 1'b1, 1'b1, 2'b11, 0, 0);
        send_col(40'hE6E5E4E3E2, 1'b1, 1'b1, 2'b01, 0, 0);
        send_col(40'hE7E6E5E4E3, 1'b1, 1'b1, 2'b11, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dlsc_demosaic_vng6_sequencer.md
Name: dlsc_demosaic_vng6_sequencer

Overview:
- Upstream feeder/sequencer for the VNG6 shift-register array.
- Accepts one 5-row Bayer column per handshake from the line buffers and serializes it onto a single pixel bus with a push strobe.
- Generates the 4-bit state count `st` and the global `clk_en` stall that all vng6 shiftreg/ROM instances share.
- Tracks column position and CFA phase per output pixel.

Parameters:
- DATA, 8, pixel width in bits.
- CYCLES, 12, states per output pixel; legal range 6..16; st counts 0..CYCLES-1.
- XB, 12, width of the column counter and cfg_width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- cfg_width  input  XB  columns per row minus 1; sampled only at row start.
- cfg_phase  input  2  CFA phase of pixel (0,0): bit0 = x parity, bit1 = y parity.
- in_ready  output  1  upstream may transfer.
- in_valid  input  1  upstream column valid.
- in_data  input  5*DATA  column, row 0 in the LSBs.
- clk_en  output  1  global pipeline enable for the VNG6 array.
- st  output  4  current state.
- push  output  1  shift in_data row onto the shift registers this cycle.
- out_data  output  DATA  row pixel being pushed.
- out_first  output  1  current pixel is the first column of a row.
- out_last  output  1  current pixel is the last column of a row.
- out_phase  output  2  CFA phase of the current pixel.
- down_ready  input  1  downstream accepts results; low stalls the array.

Behaviour:
- Reset (async):
  - st=0, clk_en=0, push=0, out_data=0, out_first=1, out_last=0, in_ready=0.
  - Column counter=0; row parity=cfg_phase[1] after first sample; captured column register=0.
- States: IDLE (waiting for a column at st=0) and RUN (st 1..CYCLES-1).
- clk_en:
  - Equals down_ready && (st!=0 || in_valid).
  - Combinational from registered state plus in_valid/down_ready.
  - Everything else below advances only when clk_en=1.
- in_ready = (st==0) && down_ready.
  - Transfer occurs when in_valid && in_ready, i.e. exactly when st==0 && clk_en.
  - in_data is captured into a 5*DATA register on transfer.
- st sequencing:
  - On each clk_en, st <= (st==CYCLES-1) ? 0 : st+1.
  - No bubble between pixels when in_valid is held high, so throughput is 1 column per CYCLES enabled cycles.
- Push and data:
  - push and out_data are registered, updated on clk_en.
  - push=1 for st values 1..5 after a transfer; out_data = captured row (st-1).
  - So rows 0..4 are pushed in order, one per cycle, 1 cycle after capture.
  - push=0 in all other states.
  - When clk_en=0, push/out_data hold their values; consumers qualify push with clk_en.
- Column tracking (updated on transfer):
  - out_first = (col==0).
  - out_last = (col==width_latched).
  - col <= out_last ? 0 : col+1.
  - width_latched is loaded from cfg_width when col==0.
  - At row wrap, row parity toggles.
  - out_phase = {row_parity, cfg_phase[0]^col[0]}.
  - First row after reset uses row_parity = cfg_phase[1].
- Boundaries:
  - cfg_width=0: every column is both first and last, and row parity toggles on every column.
  - down_ready dropping mid-pixel freezes st, push and counters.
  - Reset mid-pixel discards the captured column; the upstream is expected to restart the frame.
  - in_valid high while st!=0 is ignored (in_ready=0), and in_data must stay stable until the transfer.

Optional Feature:
- Macro DLSC_DEMOSAIC_VNG6_SEQ_STATS_EN.
- When defined, adds outputs stat_starve (32) and stat_backpressure (32), plus input stat_clear.
  - stat_starve counts cycles with st==0 && !in_valid && down_ready.
  - stat_backpressure counts cycles with !down_ready.
  - Both counters saturate at all-ones, clear on stat_clear, and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package dlsc_demosaic_vng6_pkg holds:
  - ROWS=5 and ST_BITS=4.
  - CFA phase encoding constants: PH_RG=0, PH_GR=1, PH_GB=2, PH_BG=3.
  - The default CYCLES value, shared with the ROM INDEX tables.
- One natural sub-module: dlsc_demosaic_vng6_colcnt, covering the column counter, width latch, first/last flags and phase tracking.

Test Plan:
- Back-to-back stream, CYCLES=12, cfg_width=3, in_valid held 1 → a transfer every 12 clocks; push high at st 1..5 carrying rows 0,1,2,3,4 in order; out_first on columns 0,4,8; out_last on columns 3,7.
- in_valid low for 7 cycles at st=0 → clk_en=0, st held at 0, push unchanged; with STATS_EN, stat_starve increments by 7.
- down_ready low for 3 cycles at st=3 → st stays 3 and col is unchanged; resumes at st=4 with the correct row-3 push.
- cfg_phase=2'b01, cfg_width=1 → out_phase sequence 01,00,11,10,01.
- Async rst asserted at st=7 mid-pixel → all outputs at reset values immediately; the first pixel after release is out_first=1, col=0.
- cfg_width=0 → out_first=out_last=1 every column, and row parity toggles every column.
